// File: rtl/ita_package.sv
// Shared types for the ITA output writer: FSM state encoding and the latched layout config.
// Struct field widths match the writer's default AddrWidth/CntWidth.
package ita_package;

    localparam int unsigned OW_ADDR_W = 32;
    localparam int unsigned OW_CNT_W  = 16;

    typedef enum logic [1:0] {
        OW_IDLE  = 2'd0,
        OW_RUN   = 2'd1,
        OW_DRAIN = 2'd2,
        OW_DONE  = 2'd3
    } out_writer_state_e;

    typedef struct packed {
        logic [OW_ADDR_W-1:0] base;
        logic [OW_CNT_W-1:0]  stride;
        logic [OW_CNT_W-1:0]  tile_rows;
        logic [OW_CNT_W-1:0]  col_tiles;
        logic [OW_CNT_W-1:0]  row_tiles;
    } out_writer_cfg_t;

    // A layout with any zero dimension produces no beats.
    function automatic logic cfg_is_empty(input out_writer_cfg_t cfg);
        return (cfg.tile_rows == '0) || (cfg.col_tiles == '0) || (cfg.row_tiles == '0);
    endfunction

endpackage

// File: rtl/ita_output_addrgen.sv
// Tiled output address generator: walks row-in-tile (inner), tile column, tile row (outer)
// and keeps the beat address up to date with adders only.
module ita_output_addrgen
    import ita_package::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_init,
    input  out_writer_cfg_t      i_cfg,
    input  logic                 i_next,
    output logic [OW_ADDR_W-1:0] o_addr,
    output logic                 o_last
);

    localparam logic [OW_ADDR_W-1:0] BeatBytes = OW_ADDR_W'(N);

    logic [OW_CNT_W-1:0]  r_r, r_tc, r_tr;
    logic [OW_CNT_W-1:0]  r_r_max, r_tc_max, r_tr_max;
    logic [OW_ADDR_W-1:0] r_addr, r_stride, r_tile_base, r_next_trow;
    logic [OW_ADDR_W-1:0] w_step, w_next_tile, w_new_trow;
    logic                 w_row_end, w_col_end, w_trow_end;

    assign w_step      = r_addr + r_stride;
    assign w_next_tile = r_tile_base + BeatBytes;
    assign w_row_end   = (r_r == r_r_max);
    assign w_col_end   = (r_tc == r_tc_max);
    assign w_trow_end  = (r_tr == r_tr_max);
    // Row 0 of the next tile row sits one stride past the last row of tile column 0.
    assign w_new_trow  = (r_tc == '0) ? w_step : r_next_trow;

    assign o_addr = r_addr;
    assign o_last = w_row_end && w_col_end && w_trow_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r         <= '0;
            r_tc        <= '0;
            r_tr        <= '0;
            r_r_max     <= '0;
            r_tc_max    <= '0;
            r_tr_max    <= '0;
            r_addr      <= '0;
            r_stride    <= '0;
            r_tile_base <= '0;
            r_next_trow <= '0;
        end else if (i_init) begin
            r_r         <= '0;
            r_tc        <= '0;
            r_tr        <= '0;
            r_r_max     <= i_cfg.tile_rows - OW_CNT_W'(1);
            r_tc_max    <= i_cfg.col_tiles - OW_CNT_W'(1);
            r_tr_max    <= i_cfg.row_tiles - OW_CNT_W'(1);
            r_addr      <= i_cfg.base;
            r_stride    <= OW_ADDR_W'(i_cfg.stride);
            r_tile_base <= i_cfg.base;
            r_next_trow <= i_cfg.base;
        end else if (i_next) begin
            if (!w_row_end) begin
                r_r    <= r_r + OW_CNT_W'(1);
                r_addr <= w_step;
            end else if (!w_col_end) begin
                r_r         <= '0;
                r_tc        <= r_tc + OW_CNT_W'(1);
                r_tile_base <= w_next_tile;
                r_addr      <= w_next_tile;
                if (r_tc == '0) begin
                    r_next_trow <= w_step;
                end
            end else begin
                r_r         <= '0;
                r_tc        <= '0;
                r_tr        <= r_tr + OW_CNT_W'(1);
                r_tile_base <= w_new_trow;
                r_addr      <= w_new_trow;
            end
        end
    end

endmodule

// File: rtl/ita_output_writer.sv
// Writes the ITA output stream to memory in a tiled layout through a single registered request stage.
// Optional stall counter enabled by ITA_OUT_WRITER_PERF_EN.
module ita_output_writer
    import ita_package::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned WI        = 8,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [CntWidth-1:0]  row_stride_i,
    input  logic [CntWidth-1:0]  tile_rows_i,
    input  logic [CntWidth-1:0]  col_tiles_i,
    input  logic [CntWidth-1:0]  row_tiles_i,
    input  logic                 inp_valid_i,
    output logic                 inp_ready_o,
    input  logic [N*WI-1:0]      inp_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [N*WI-1:0]      mem_wdata_o,
    output logic [N-1:0]         mem_be_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int unsigned DataWidth = N * WI;

    out_writer_state_e    r_state, w_state_next;
    out_writer_cfg_t      w_cfg;
    logic                 w_start, w_accept, w_gnt, w_last;
    logic [OW_ADDR_W-1:0] w_ag_addr;
    logic                 r_stage_valid;
    logic [OW_ADDR_W-1:0] r_stage_addr;
    logic [DataWidth-1:0] r_stage_data;
    logic                 r_busy, r_done;

    assign w_cfg = '{
        base:      OW_ADDR_W'(base_addr_i),
        stride:    OW_CNT_W'(row_stride_i),
        tile_rows: OW_CNT_W'(tile_rows_i),
        col_tiles: OW_CNT_W'(col_tiles_i),
        row_tiles: OW_CNT_W'(row_tiles_i)
    };

    assign w_start     = (r_state == OW_IDLE) && start_i;
    assign inp_ready_o = (r_state == OW_RUN) && (!r_stage_valid || mem_gnt_i);
    assign w_accept    = inp_valid_i && inp_ready_o;
    assign w_gnt       = r_stage_valid && mem_gnt_i;

    ita_output_addrgen #(
        .N (N)
    ) u_addrgen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_init (w_start),
        .i_cfg  (w_cfg),
        .i_next (w_accept),
        .o_addr (w_ag_addr),
        .o_last (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OW_IDLE:  if (start_i) w_state_next = cfg_is_empty(w_cfg) ? OW_DONE : OW_RUN;
            OW_RUN:   if (w_accept && w_last) w_state_next = OW_DRAIN;
            OW_DRAIN: if (w_gnt) w_state_next = OW_DONE;
            OW_DONE:  w_state_next = OW_IDLE;
            default:  w_state_next = OW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= OW_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != OW_IDLE);
            r_done  <= (r_state == OW_DONE);
        end
    end

    // Request stage: a grant and a new accept on the same edge reload it back-to-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage_valid <= 1'b0;
            r_stage_addr  <= '0;
            r_stage_data  <= '0;
        end else if (w_accept) begin
            r_stage_valid <= 1'b1;
            r_stage_addr  <= w_ag_addr;
            r_stage_data  <= inp_i;
        end else if (w_gnt) begin
            r_stage_valid <= 1'b0;
        end
    end

    assign mem_req_o   = r_stage_valid;
    assign mem_addr_o  = AddrWidth'(r_stage_addr);
    assign mem_wdata_o = r_stage_data;
    assign mem_be_o    = {N{r_stage_valid}};
    assign busy_o      = r_busy;
    assign done_o      = r_done;

`ifdef ITA_OUT_WRITER_PERF_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles a request waits for its grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
        end else if (r_stage_valid && !mem_gnt_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/ita_output_writer.md
# ita_output_writer

Downstream of the ITA top. Consumes the requantized output stream (`oup_o`/`valid_o`/`ready_i`) one N-element row segment (beat) per handshake, computes each beat's memory address from a tiled output layout, and issues single-beat write requests on a req/gnt memory port. Registered request stage, one beat per cycle sustained throughput, `done_o` pulse once the whole tensor is written.

## Interface
Parameters:
- `N`, 16: int8 elements per beat (matches ITA N).
- `WI`, 8: bits per element.
- `AddrWidth`, 32: byte address width.
- `CntWidth`, 16: width of all dimension counters and stride.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle pulse, latches config, leaves Idle.
- `base_addr_i` in AddrWidth: byte address of element (0,0).
- `row_stride_i` in CntWidth: bytes between consecutive output rows.
- `tile_rows_i` in CntWidth: beats (rows) per tile.
- `col_tiles_i` in CntWidth: tiles along columns.
- `row_tiles_i` in CntWidth: tiles along rows.
- `inp_valid_i` in 1 / `inp_ready_o` out 1: stream handshake from ITA.
- `inp_i` in N*WI: beat data.
- `mem_req_o` out 1, `mem_gnt_i` in 1: memory handshake.
- `mem_addr_o` out AddrWidth, `mem_wdata_o` out N*WI, `mem_be_o` out N: write request; `mem_be_o` is all ones whenever `mem_req_o` is high.
- `busy_o` out 1: not Idle.
- `done_o` out 1: one-cycle pulse after final grant.
- `stall_cnt_o` out 32: perf counter (see Configuration).

## Operation
- Beat order: tile row `tr` outer, tile column `tc` middle, row-in-tile `r` inner.
- addr = base + (tr*tile_rows + r)*row_stride + tc*N, computed incrementally (adders only, no multipliers), modulo 2^AddrWidth.
- FSM: Idle -> (start_i) Run -> (last beat accepted) Drain -> (final gnt) Done -> Idle.
- Idle: `inp_ready_o`=0. In Idle with `start_i`, any of `tile_rows_i`/`col_tiles_i`/`row_tiles_i` = 0 -> go directly to Done (no requests).
- Run: accept beats. Stage register holds one beat plus address. `inp_ready_o = !stage_valid || mem_gnt_i`.
- Drain: `inp_ready_o`=0; wait for stage to empty.
- Done: `done_o`=1 for exactly one cycle, then Idle.
- `start_i` outside Idle: ignored. Config is sampled only at start.
- Counters wrap as r -> 0/tc++, tc -> 0/tr++; last beat = all three at max.
- Beats arriving while Idle/Drain/Done are not accepted (stay pending upstream).

## Timing
- Reset: all outputs 0; FSM Idle; stage empty; counters 0.
- Beat accepted at edge t -> `mem_req_o`=1 with its addr/data from t+1.
- Request fields are stable until `mem_gnt_i`. Request drops the cycle after gnt unless a new beat was accepted on the same edge.
- Simultaneous gnt and new accept: stage reloads, and `mem_req_o` stays high continuously.
- With `mem_gnt_i` tied to 1: one beat per cycle. The final grant at edge t gives `done_o` at t+1, i.e. latency from the last accept is 2 cycles.
- Reset mid-operation: immediate return to Idle, stage discarded, no `done_o`.

## Configuration
- `ITA_OUT_WRITER_PERF_EN` defined: `stall_cnt_o` counts cycles with `mem_req_o && !mem_gnt_i`. The counter is saturating at 2^32-1 and cleared on `start_i` accepted in Idle.
- Not defined: counter logic is absent and `stall_cnt_o` is tied to 0.

## Structure
- `ita_package`: `out_writer_state_e` (Idle/Run/Drain/Done) and `out_writer_cfg_t`, a struct of base, stride, tile_rows, col_tiles and row_tiles.
- Sub-module `ita_output_addrgen`: counters plus incremental address, with `next_i` advance and `last_o` flag. The top keeps the FSM, stage register and perf counter.

## Test plan
- Layout check, no backpressure (N=16, base 0x1000, stride 64, tile_rows 4, col_tiles 2, row_tiles 1). Required addresses: 0x1000, 0x1040, 0x1080, 0x10C0, 0x1010, 0x1050, 0x1090, 0x10D0. Data must match the input order and `done_o` must pulse once.
- Same config, `mem_gnt_i` low 3 cycles per beat: `inp_ready_o` low while the stage is held; addresses and data unchanged; no beat lost or duplicated. With PERF_EN, `stall_cnt_o`=24.
- Zero size (`col_tiles_i`=0): `done_o` two cycles after `start_i`; `mem_req_o` never high.
- Address wrap: base 0xFFFFFFF0, stride 16, tile_rows 2, 1x1 tiles -> addresses 0xFFFFFFF0 then 0x00000000.
- `start_i` pulsed during Run is ignored; assert `rst_ni` low mid-Run -> outputs 0 immediately, `done_o` never pulses, and a fresh start completes normally.
- Gnt always high with continuous valid: 8 beats in 8 consecutive cycles, `mem_req_o` continuously high.
